// File: rtl/ssp_slv_framer.sv
// SPI mode-0 slave deframer feeding SSP_UART's parallel register bus.
// Optional macro SSP_SLV_FRAME_ERR_EN adds the FrmErr abort/overrun pulse.
module ssp_slv_framer #(
    parameter int SYNC_STAGES = 2,
    parameter int RA_W        = 3,
    parameter int DATA_W      = 12
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              SSEL_n,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    output logic              SSP_SSEL,
    output logic              SSP_SCK,
    output logic [RA_W-1:0]   SSP_RA,
    output logic              SSP_WnR,
    output logic              SSP_En,
    output logic              SSP_EOC,
    output logic [DATA_W-1:0] SSP_DI,
    input  logic [DATA_W-1:0] SSP_DO
`ifdef SSP_SLV_FRAME_ERR_EN
    ,
    output logic              FrmErr
`endif
);

    localparam int FL = RA_W + 1 + DATA_W;
    localparam int CW = $clog2(FL + 1);

    localparam logic [CW-1:0] HDR_LAST = CW'(RA_W);
    localparam logic [CW-1:0] FL_LAST  = CW'(FL - 1);
    localparam logic [CW-1:0] FL_C     = CW'(FL);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        DATA,
        DONE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] ssel_sr;
    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   sck_d;

    logic [CW-1:0]     cnt;
    logic [DATA_W-2:0] rx;
    logic [DATA_W-1:0] tx;

    logic ssel_act;
    logic sck_s;
    logic mosi_s;
    logic rise;
    logic fall;

    assign ssel_act = ~ssel_sr[SYNC_STAGES-1];
    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign mosi_s   = mosi_sr[SYNC_STAGES-1];
    assign rise     = sck_s & ~sck_d;
    assign fall     = ~sck_s & sck_d;
    assign SSP_SCK  = sck_d;

    // Bring the SPI pins into the Clk domain; select idles deasserted.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ssel_sr <= '1;
            sck_sr  <= '0;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
        end else begin
            ssel_sr <= {ssel_sr[SYNC_STAGES-2:0], SSEL_n};
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], SCK};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
            sck_d   <= sck_s;
        end
    end

    // Frame FSM: header capture, data shifting, end-of-cycle and aborts.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rx       <= '0;
            tx       <= '0;
            MISO     <= 1'b0;
            MISO_OE  <= 1'b0;
            SSP_SSEL <= 1'b0;
            SSP_RA   <= '0;
            SSP_WnR  <= 1'b0;
            SSP_En   <= 1'b0;
            SSP_EOC  <= 1'b0;
            SSP_DI   <= '0;
`ifdef SSP_SLV_FRAME_ERR_EN
            FrmErr   <= 1'b0;
`endif
        end else begin
            SSP_EOC  <= 1'b0;
`ifdef SSP_SLV_FRAME_ERR_EN
            FrmErr   <= 1'b0;
`endif
            SSP_SSEL <= ssel_act;
            MISO_OE  <= ssel_act;
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ssel_act) begin
                        state <= HDR;
                        cnt   <= '0;
                        rx    <= '0;
                    end
                end
                HDR: begin
                    if (!ssel_act) begin
                        state  <= IDLE;
                        SSP_En <= 1'b0;
                        cnt    <= '0;
                        MISO   <= 1'b0;
`ifdef SSP_SLV_FRAME_ERR_EN
                        FrmErr <= 1'b1;
`endif
                    end else if (rise) begin
                        rx  <= {rx[DATA_W-3:0], mosi_s};
                        cnt <= cnt + CW'(1);
                        if (cnt == HDR_LAST) begin
                            SSP_RA  <= rx[RA_W-1:0];
                            SSP_WnR <= mosi_s;
                            SSP_En  <= 1'b1;
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (!ssel_act) begin
                        state  <= IDLE;
                        SSP_En <= 1'b0;
                        cnt    <= '0;
                        MISO   <= 1'b0;
`ifdef SSP_SLV_FRAME_ERR_EN
                        FrmErr <= 1'b1;
`endif
                    end else begin
                        state <= DATA;
                        if (fall) begin
                            MISO <= SSP_DO[DATA_W-1];
                            tx   <= {SSP_DO[DATA_W-2:0], 1'b0};
                        end else begin
                            tx <= SSP_DO;
                        end
                    end
                end
                DATA: begin
                    if (rise && cnt == FL_LAST) begin
                        SSP_DI  <= {rx, mosi_s};
                        SSP_EOC <= 1'b1;
                        SSP_En  <= 1'b0;
                        cnt     <= FL_C;
                        MISO    <= 1'b0;
                        state   <= DONE;
                    end else if (!ssel_act) begin
                        state  <= IDLE;
                        SSP_En <= 1'b0;
                        cnt    <= '0;
                        MISO   <= 1'b0;
`ifdef SSP_SLV_FRAME_ERR_EN
                        FrmErr <= 1'b1;
`endif
                    end else begin
                        if (rise) begin
                            rx  <= {rx[DATA_W-3:0], mosi_s};
                            cnt <= cnt + CW'(1);
                        end
                        if (fall) begin
                            MISO <= tx[DATA_W-1];
                            tx   <= {tx[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    MISO <= 1'b0;
                    if (!ssel_act) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (rise) begin
`ifdef SSP_SLV_FRAME_ERR_EN
                        FrmErr <= 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    MISO  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssp_slv_framer.sv
// Directed frame-table bench for ssp_slv_framer.
// Frames are driven as an SPI mode-0 master at Clk/8.
module tb_ssp_slv_framer;

    logic        Clk;
    logic        Rst;
    logic        SSEL_n;
    logic        SCK;
    logic        MOSI;
    logic        MISO;
    logic        MISO_OE;
    logic        SSP_SSEL;
    logic        SSP_SCK;
    logic [2:0]  SSP_RA;
    logic        SSP_WnR;
    logic        SSP_En;
    logic        SSP_EOC;
    logic [11:0] SSP_DI;
    logic [11:0] SSP_DO;
`ifdef SSP_SLV_FRAME_ERR_EN
    logic        FrmErr;
`endif

    logic [11:0] do_mem [8];
    assign SSP_DO = do_mem[SSP_RA];

    ssp_slv_framer dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .SSEL_n   (SSEL_n),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .MISO_OE  (MISO_OE),
        .SSP_SSEL (SSP_SSEL),
        .SSP_SCK  (SSP_SCK),
        .SSP_RA   (SSP_RA),
        .SSP_WnR  (SSP_WnR),
        .SSP_En   (SSP_En),
        .SSP_EOC  (SSP_EOC),
        .SSP_DI   (SSP_DI),
        .SSP_DO   (SSP_DO)
`ifdef SSP_SLV_FRAME_ERR_EN
        ,
        .FrmErr   (FrmErr)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  ra;
        logic        wnr;
        logic [11:0] data;
        logic [11:0] dov;
        int          nb;
        int          eoc;
        int          ferr;
    } vec_t;

    vec_t vecs[6];

    int tests = 0;
    int fails = 0;

    int          eoc_cnt = 0;
    logic [11:0] last_di = '0;
`ifdef SSP_SLV_FRAME_ERR_EN
    int          ferr_cnt = 0;
`endif

    // Count one-Clk pulses away from the active edge.
    always @(negedge Clk) begin
        if (SSP_EOC === 1'b1) begin
            eoc_cnt = eoc_cnt + 1;
            last_di = SSP_DI;
        end
`ifdef SSP_SLV_FRAME_ERR_EN
        if (FrmErr === 1'b1) ferr_cnt = ferr_cnt + 1;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] ra, input logic wnr,
                                input logic [11:0] data,
                                input logic [11:0] dov, input int nb,
                                input int eoc, input int ferr);
        vec_t v;
        v.ra   = ra;
        v.wnr  = wnr;
        v.data = data;
        v.dov  = dov;
        v.nb   = nb;
        v.eoc  = eoc;
        v.ferr = ferr;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] w;
        logic [15:0] mw;
        logic        extra;
        logic        en_log [20];
        int          e0;
`ifdef SSP_SLV_FRAME_ERR_EN
        int          f0;
        f0 = ferr_cnt;
`endif
        w  = {v.ra, v.wnr, v.data};
        mw = '0;
        extra = 1'b0;
        do_mem[v.ra] = v.dov;
        e0 = eoc_cnt;
        SSEL_n = 1'b0;
        repeat (4) @(negedge Clk);
        for (int i = 0; i < v.nb; i++) begin
            MOSI = (i < 16) ? w[15-i] : 1'b0;
            repeat (4) @(negedge Clk);
            if (i < 16) mw[15-i] = MISO;
            else extra = extra | MISO;
            SCK = 1'b1;
            repeat (4) @(negedge Clk);
            en_log[i] = SSP_En;
            SCK = 1'b0;
        end
        repeat (4) @(negedge Clk);
        SSEL_n = 1'b1;
        MOSI = 1'b0;
        repeat (16) @(negedge Clk);
        chk({tag, "_eoc"}, eoc_cnt - e0, v.eoc);
        if (v.eoc > 0) chk({tag, "_di"}, last_di, v.data);
        chk({tag, "_ra"}, SSP_RA, v.ra);
        chk({tag, "_wnr"}, SSP_WnR, v.wnr);
        if (v.nb >= 16) chk({tag, "_miso"}, mw, {4'b0, v.dov});
        if (v.nb > 16) chk({tag, "_miso_ovr"}, extra, 0);
        if (v.nb >= 5) begin
            chk({tag, "_en_b3"}, en_log[2], 0);
            chk({tag, "_en_b4"}, en_log[3], 1);
        end
        chk({tag, "_en_end"}, SSP_En, 0);
        chk({tag, "_sel_end"}, SSP_SSEL, 0);
        chk({tag, "_oe_end"}, MISO_OE, 0);
`ifdef SSP_SLV_FRAME_ERR_EN
        chk({tag, "_ferr"}, ferr_cnt - f0, v.ferr);
`endif
    endtask

    initial begin
        logic [15:0] w;
        Rst    = 1'b0;
        SSEL_n = 1'b1;
        SCK    = 1'b0;
        MOSI   = 1'b0;
        for (int i = 0; i < 8; i++) do_mem[i] = '0;

        vecs[0] = mk(3'd3, 1'b1, 12'hA5C, 12'h5A5, 16, 1, 0);
        vecs[1] = mk(3'd5, 1'b0, 12'h0F0, 12'h3C9, 16, 1, 0);
        vecs[2] = mk(3'd6, 1'b1, 12'h7E1, 12'h111, 9, 0, 1);
        vecs[3] = mk(3'd2, 1'b1, 12'h001, 12'h800, 18, 1, 2);
        vecs[4] = mk(3'd1, 1'b1, 12'h123, 12'hABC, 16, 1, 0);
        vecs[5] = mk(3'd4, 1'b1, 12'h456, 12'h0FF, 16, 1, 0);

        repeat (3) @(negedge Clk);
        chk("rst_miso", MISO, 0);
        chk("rst_oe", MISO_OE, 0);
        chk("rst_sel", SSP_SSEL, 0);
        chk("rst_en", SSP_En, 0);
        chk("rst_eoc", SSP_EOC, 0);
        chk("rst_ra", SSP_RA, 0);
        chk("rst_di", SSP_DI, 0);
        Rst = 1'b1;
        repeat (4) @(negedge Clk);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], $sformatf("V%0d", k));
        end

        w = {3'd6, 1'b1, 12'hF0F};
        do_mem[6] = 12'h0AA;
        SSEL_n = 1'b0;
        repeat (4) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            MOSI = w[15-i];
            repeat (4) @(negedge Clk);
            SCK = 1'b1;
            repeat (4) @(negedge Clk);
            SCK = 1'b0;
        end
        repeat (2) @(negedge Clk);
        chk("t5_pre_en", SSP_En, 1);
        chk("t5_pre_oe", MISO_OE, 1);
        #2 Rst = 1'b0;
        #1;
        chk("t5_en", SSP_En, 0);
        chk("t5_oe", MISO_OE, 0);
        chk("t5_sel", SSP_SSEL, 0);
        chk("t5_ra", SSP_RA, 0);
        chk("t5_wnr", SSP_WnR, 0);
        chk("t5_miso", MISO, 0);
        SSEL_n = 1'b1;
        MOSI = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        repeat (4) @(negedge Clk);
        run_vec(mk(3'd0, 1'b1, 12'hFFF, 12'h321, 16, 1, 0), "T5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
